// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the 4-digit scanned 7-segment driver.
package seg_scan_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  // Lit-high digit patterns, bit0=a .. bit6=g
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;

  // Idle (all off) levels on the active-low pins
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;
  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  // One-hot-low anode enable for the selected digit
  function automatic logic [NUM_DIGITS-1:0] an_drive(input logic [1:0] d);
    return ~(NUM_DIGITS'(1) << d);
  endfunction

  // Lit-high pattern to active-low cathodes
  function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] p);
    return ~p;
  endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: slot_cnt 0..SLOT_CYC-1, digit index 0..3, frame boundary flag.
module seg_slot_timer #(
  parameter int SLOT_CYC = 4,
  parameter int CW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] slot_cnt,
  output logic [1:0]    digit,
  output logic          boundary
);
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYC - 1);

  logic wrap;
  assign wrap     = (slot_cnt == LAST);
  assign boundary = wrap && (digit == 2'd3);

  // Advance slot counter; step digit at each slot wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      digit    <= 2'd0;
    end else if (wrap) begin
      slot_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
// New patterns are staged in a shadow register and committed only at the
// frame boundary so a frame never shows a mix of old and new digits.
// Optional macro SEG_SCAN_DIM_EN adds dim_level and a 4-bit PWM gate.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_CYC  = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]                  dim_level,
`endif
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            seg,
  output logic                        frame_done
);
  localparam int SLOT_CYC = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int CW       = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic          boundary;

  logic [NUM_DIGITS-1:0][SEG_W-1:0] shadow, active;
  logic                             pending;

  phase_t                phase;
  logic [NUM_DIGITS-1:0] next_an;
  logic [SEG_W-1:0]      next_seg;

  seg_slot_timer #(.SLOT_CYC(SLOT_CYC), .CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .slot_cnt (slot_cnt),
    .digit    (digit),
    .boundary (boundary)
  );

  assign frame_done = boundary;

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] pwm_cnt;

  // Free-running brightness PWM phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= 4'd0;
    else     pwm_cnt <= pwm_cnt + 4'd1;
  end
`endif

  // Stage loads in shadow; commit at frame boundary (a same-cycle load wins)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= seg_in;
      if (boundary) begin
        active  <= load ? seg_in : (pending ? shadow : active);
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Slot phase decode: leading BLANK_CYC cycles dark to kill ghosting
  always_comb begin
    phase    = (slot_cnt < BLANK_C) ? PH_BLANK : PH_DRIVE;
`ifdef SEG_SCAN_DIM_EN
    if (pwm_cnt >= dim_level) phase = PH_BLANK;
`endif
    next_an  = AN_OFF;
    next_seg = SEG_OFF;
    if (phase == PH_DRIVE) begin
      next_an  = an_drive(digit);
      next_seg = seg_drive(active[digit]);
    end
  end

  // Registered pin drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= next_an;
      seg <= next_seg;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (SLOT_CYC=4, BLANK_CYC=1, 16-cycle frame).
// With SEG_SCAN_DIM_EN defined only the brightness sequence runs.
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [27:0] seg_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]  dim_level;
`endif

  int checks = 0;
  int errors = 0;
  int k      = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.CLK_HZ(1600), .REFRESH_HZ(100), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .seg_in     (seg_in),
`ifdef SEG_SCAN_DIM_EN
    .dim_level  (dim_level),
`endif
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  // Per-cycle pin invariants
  always @(negedge clk) begin
    checks++;
    assert ($countones(~an) <= 1)
      else begin errors++; $error("FAIL anode_onehot observed an=%h expected <=1 low", an); end
    checks++;
    assert (an != 4'hF || seg === 7'h7F)
      else begin errors++; $error("FAIL blank_segs observed seg=%h expected 7f (an=%h)", seg, an); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask

`ifndef SEG_SCAN_DIM_EN
  // Run n cycles of a frame aligned to digit0/slot0, checking pins against
  // the pattern expected on screen; optionally strobe load at positions la0/la1.
  task automatic run_frame(input logic [3:0][6:0] pat, input int n,
                           input int la0, input logic [27:0] lv0,
                           input int la1, input logic [27:0] lv1);
    logic [3:0] ea;
    logic [6:0] es;
    int p, d;
    for (int i = 0; i < n; i++) begin
      load = (i == la0) || (i == la1);
      if (i == la0) seg_in = lv0;
      if (i == la1) seg_in = lv1;
      @(negedge clk);
      k++;
      load = 1'b0;
      p = i % 4;
      d = i / 4;
      if (p == 0) begin
        ea = 4'hF;
        es = 7'h7F;
      end else begin
        ea = ~(4'b0001 << d);
        es = ~pat[d];
      end
      chk($sformatf("an[k=%0d]", k), {28'd0, an}, {28'd0, ea});
      chk($sformatf("seg[k=%0d]", k), {25'd0, seg}, {25'd0, es});
      chk($sformatf("frame_done[k=%0d]", k), {31'd0, frame_done}, {31'd0, (i == 14)});
    end
  endtask
`endif

  initial begin
    logic [3:0][6:0] zero, p3f, p2, pb, p8;
    zero = '0;
    p3f  = {4{7'h3F}};
    p2   = {7'h3F, 7'h3F, 7'h3F, 7'h5B};
    pb   = {7'h66, 7'h4F, 7'h5B, 7'h06};
    p8   = {4{7'h7F}};
    rst = 1'b1; load = 1'b0; seg_in = '0;
`ifdef SEG_SCAN_DIM_EN
    dim_level = 4'd4;
`endif
    repeat (2) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_frame_done", {31'd0, frame_done}, 32'h0);
    rst = 1'b0;
    k = 0;

`ifdef SEG_SCAN_DIM_EN
    begin
      int lit;
      load = 1'b1; seg_in = p3f;
      @(negedge clk); load = 1'b0;
      repeat (15) @(negedge clk);
      lit = 0;
      repeat (64) begin @(negedge clk); if (an != 4'hF) lit++; end
      chk("dim4_lit_cycles", lit, 32'd12);
      dim_level = 4'd0;
      @(negedge clk);
      lit = 0;
      repeat (64) begin @(negedge clk); if (an != 4'hF) lit++; end
      chk("dim0_lit_cycles", lit, 32'd0);
    end
`else
    // Idle frame, then mid-frame load that must wait for the boundary
    run_frame(zero, 16, -1, '0, -1, '0);
    run_frame(zero, 16, 5, p3f, -1, '0);
    run_frame(p3f, 16, -1, '0, -1, '0);
    // Two loads in one frame: last wins
    run_frame(p3f, 16, 3, {7'h3F, 7'h3F, 7'h3F, 7'h06}, 9, p2);
    run_frame(p2, 16, -1, '0, -1, '0);
    // Load on the boundary cycle itself
    run_frame(p2, 16, 15, pb, -1, '0);
    run_frame(pb, 16, -1, '0, -1, '0);
    run_frame(pb, 16, -1, '0, -1, '0);
    // Reset during digit-2 drive
    run_frame(pb, 11, -1, '0, -1, '0);
    chk("pre_rst_an", {28'd0, an}, 32'hB);
    rst = 1'b1;
    #1;
    chk("midrst_an", {28'd0, an}, 32'hF);
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    run_frame(zero, 16, 0, p8, -1, '0);
    run_frame(p8, 16, -1, '0, -1, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
